mapache_video_top: RTL and testbench



---
 rtl/mapache_video_top_if.sv | 31 +++
 rtl/mapache_video_top.sv | 149 ++++++++++++++
 tb/tb_mapache_video_top.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mapache_video_top_if.sv
// CPU-side address/control bus of the console video/bus block.
// master: CPU side drives address/write strobe; slave: block drives selects/irq.
interface mapache_video_top_if;
  logic [15:0] cpu_address;
  logic        write_enable;
  logic [14:0] output_address;
  logic        SELECT_ram;
  logic        SELECT_rom;
  logic        SELECT_controller;
  logic        vblank_irq;

  modport master (
    output cpu_address,
    output write_enable,
    input  output_address,
    input  SELECT_ram,
    input  SELECT_rom,
    input  SELECT_controller,
    input  vblank_irq
  );

  modport slave (
    input  cpu_address,
    input  write_enable,
    output output_address,
    output SELECT_ram,
    output SELECT_rom,
    output SELECT_controller,
    output vblank_irq
  );
endinterface

// File: rtl/mapache_video_top.sv
// Video/bus glue: address decode, 2304-byte VRAM, VBlank regs, 640x480 VGA.
// Ports: clk_12_5875/rst, bus (CPU addr/we/selects/irq), data (inout), r/g/b, syncs.
module mapache_video_top (
  input  logic       clk_12_5875,
  input  logic       rst,
  mapache_video_top_if.slave bus,
  inout  wire  [7:0] data,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       hsync,
  output logic       vsync
);

  localparam logic [9:0] H_LAST  = 10'd799;
  localparam logic [9:0] V_LAST  = 10'd524;
  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] V_VIS   = 10'd480;
  localparam logic [9:0] HS_BEG  = 10'd656;
  localparam logic [9:0] HS_END  = 10'd751;
  localparam logic [9:0] VS_BEG  = 10'd490;
  localparam logic [9:0] VS_END  = 10'd491;
  localparam logic [9:0] IRQ_V   = 10'd479;
  localparam logic [11:0] NT_OFS = 12'h200;

  logic [15:0] a;
  logic        we;
  logic        sel_ram;
  logic        sel_vram;
  logic        sel_rom;
  logic        sel_reg;
  logic        sel_ctl;
  logic        oe;
  logic [11:0] vidx;
  logic [7:0]  rd_q;
  logic        irq_q;
  logic        irq_clr;
  logic        in_vblank;

  logic [7:0]  vram [0:2303];

  logic [9:0]  h;
  logic [9:0]  v;
  logic        vis;
  logic [10:0] tile;
  logic [11:0] nt_idx;
  logic        h_wrap;
  logic        irq_set;

  assign a  = bus.cpu_address;
  assign we = bus.write_enable;

  // Mutually exclusive region flags; 0x7004-0x7FFF falls in none.
  assign sel_ram  = a < 16'h3700;
  assign sel_vram = (a >= 16'h3700)
                  && (a <= 16'h3FFF);
  assign sel_rom  = a[15]
                  | ((a >= 16'h4000)
                  && (a <= 16'h6FFF));
  assign sel_reg  = a[15:1] == 15'h3800;
  assign sel_ctl  = a[15:1] == 15'h3801;

  assign bus.output_address    = a[14:0];
  assign bus.SELECT_ram        = sel_ram;
  assign bus.SELECT_rom        = sel_rom;
  assign bus.SELECT_controller = sel_ctl;
  assign bus.vblank_irq        = irq_q;

  // 0x3700..0x3FFF maps to 0x000..0x8FF.
  assign vidx = a[11:0] - 12'h700;

  assign oe   = !we && (sel_vram || sel_reg);
  assign data = oe ? rd_q : 8'bz;

  assign in_vblank = v >= V_VIS;
  assign irq_clr   = we && sel_reg && a[0];

  // VRAM is never reset; the CPU port works during reset.
  always_ff @(posedge clk_12_5875) begin
    if (we && sel_vram) begin
      vram[vidx] <= data;
    end
    if (sel_vram) begin
      rd_q <= vram[vidx];
    end else if (a[0]) begin
      rd_q <= {7'd0, irq_q};
    end else begin
      rd_q <= {7'd0, in_vblank};
    end
  end

  assign h_wrap  = h == H_LAST;
  assign irq_set = h_wrap && (v == IRQ_V);

  // Nametable is addressed as 32 per row even
  // though 40 tiles are visible per line.
  assign vis    = (h < H_VIS) && (v < V_VIS);
  assign tile   = {1'b0, v[8:4], 5'd0}
                + {5'd0, h[9:4]};
  assign nt_idx = NT_OFS + {1'b0, tile};

  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h_wrap) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // Set beats clear when both land on one edge.
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else if (irq_set) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  // Colour and syncs share one register stage so
  // they stay aligned to the same (h,v).
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      r     <= '0;
      g     <= '0;
      b     <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      if (vis) begin
        r <= vram[nt_idx][5:4];
        g <= vram[nt_idx][3:2];
        b <= vram[nt_idx][1:0];
      end else begin
        r <= '0;
        g <= '0;
        b <= '0;
      end
      hsync <= !((h >= HS_BEG) && (h <= HS_END));
      vsync <= !((v >= VS_BEG) && (v <= VS_END));
    end
  end

endmodule

// File: tb/tb_mapache_video_top.sv
// Directed bench for mapache_video_top: decode, VRAM, VBlank irq, VGA timing.
// Tracks the frame position itself and checks outputs one clock behind it.
module tb_mapache_video_top;

  localparam int FRAME = 420000;

  logic       clk_12_5875 = 1'b0;
  logic       rst;
  wire  [7:0] data;
  logic [7:0] tb_dout;
  logic       tb_oe;
  logic [1:0] r;
  logic [1:0] g;
  logic [1:0] b;
  logic       hsync;
  logic       vsync;

  int total = 0;
  int bad   = 0;
  int pos   = 0;

  mapache_video_top_if bus ();

  assign data = tb_oe ? tb_dout : 8'bz;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup pu (data[i]);
  end

  mapache_video_top dut (
    .clk_12_5875 (clk_12_5875),
    .rst         (rst),
    .bus         (bus),
    .data        (data),
    .r           (r),
    .g           (g),
    .b           (b),
    .hsync       (hsync),
    .vsync       (vsync)
  );

  always #5 clk_12_5875 = ~clk_12_5875;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  // pos = counter index the DUT holds after the edge.
  task automatic tick();
    @(posedge clk_12_5875);
    if (rst) pos = 0;
    else     pos = (pos + 1) % FRAME;
    #1;
  endtask

  function automatic int out_idx();
    return (pos + FRAME - 1) % FRAME;
  endfunction

  // Advance until the outputs show pixel (hh,vv).
  task automatic wait_out(input int hh, input int vv);
    int tgt;
    tgt = vv * 800 + hh;
    for (int n = 0; n < FRAME + 2; n++) begin
      if (out_idx() == tgt) break;
      tick();
    end
    if (out_idx() != tgt)
      chk("wait_pos", out_idx(), tgt);
  endtask

  task automatic cpu_wr(input logic [15:0] ad,
                        input logic [7:0] val);
    bus.cpu_address  = ad;
    bus.write_enable = 1'b1;
    tb_dout          = val;
    tb_oe            = 1'b1;
    tick();
    bus.write_enable = 1'b0;
    tb_oe            = 1'b0;
  endtask

  function automatic logic [5:0] rgb();
    return {r, g, b};
  endfunction

  logic [15:0] dec_ad [14] = '{
    16'h0000, 16'h36FF, 16'h4000, 16'h4001,
    16'h6FFF, 16'h8000, 16'hFFFF, 16'h7002,
    16'h7003, 16'h7000, 16'h7001, 16'h3700,
    16'h7004, 16'h3FFF
  };
  // {ram, rom, controller}
  logic [2:0] dec_ex [14] = '{
    3'b100, 3'b100, 3'b010, 3'b010,
    3'b010, 3'b010, 3'b010, 3'b001,
    3'b001, 3'b000, 3'b000, 3'b000,
    3'b000, 3'b000
  };

  initial begin
    int lows;
    int first;
    logic [15:0] ad;

    rst              = 1'b1;
    tb_oe            = 1'b0;
    tb_dout          = 8'h00;
    bus.cpu_address  = 16'h0000;
    bus.write_enable = 1'b0;
    tick();
    tick();

    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_rgb", rgb(), 0);
    chk("rst_irq", bus.vblank_irq, 0);

    for (int i = 0; i < 14; i++) begin
      ad = dec_ad[i];
      bus.cpu_address = ad;
      #1;
      chk($sformatf("sel_%h", ad),
          {bus.SELECT_ram, bus.SELECT_rom,
           bus.SELECT_controller},
          dec_ex[i]);
      chk($sformatf("oaddr_%h", ad),
          bus.output_address, ad[14:0]);
    end

    // Writes during reset land in VRAM.
    cpu_wr(16'h3700, 8'hEA);
    cpu_wr(16'h3900, 8'h30);
    cpu_wr(16'h3901, 8'h2D);
    cpu_wr(16'h3920, 8'hC7);

    bus.cpu_address = 16'h3700;
    rst = 1'b0;
    tick();
    chk("rd_vram", data, 8'hEA);
    chk("pix_0_0", rgb(), 6'h30);

    bus.cpu_address = 16'h0000;
    #1;
    chk("hiz_ext", data, 8'hFF);
    bus.cpu_address  = 16'h3700;
    bus.write_enable = 1'b1;
    #1;
    chk("hiz_we", data, 8'hFF);
    bus.write_enable = 1'b0;

    wait_out(16, 0);
    chk("pix_16_0", rgb(), 6'h2D);
    wait_out(655, 0);
    chk("hs_655", hsync, 1);
    wait_out(656, 0);
    chk("hs_656", hsync, 0);
    wait_out(751, 0);
    chk("hs_751", hsync, 0);
    wait_out(752, 0);
    chk("hs_752", hsync, 1);
    wait_out(0, 16);
    chk("pix_0_16", rgb(), 6'h07);
    wait_out(640, 16);
    chk("pix_blank", rgb(), 0);

    bus.cpu_address = 16'h7000;
    wait_out(798, 479);
    chk("irq_pre", bus.vblank_irq, 0);
    chk("vb_pre", data, 8'h00);
    wait_out(799, 479);
    chk("irq_set", bus.vblank_irq, 1);
    wait_out(0, 480);
    chk("vb_480", data, 8'h01);
    chk("pix_vb", rgb(), 0);
    chk("irq_hold", bus.vblank_irq, 1);

    bus.cpu_address = 16'h7001;
    tick();
    chk("rd_irq", data, 8'h01);
    cpu_wr(16'h7001, 8'h5A);
    chk("irq_clr", bus.vblank_irq, 0);
    bus.cpu_address = 16'h7000;
    tick();
    chk("vb_after", data, 8'h01);

    wait_out(0, 482);
    lows = 0;
    for (int n = 0; n < 800; n++) begin
      tick();
      if (!hsync) lows++;
    end
    chk("hs_width", lows, 96);

    wait_out(0, 484);
    lows  = 0;
    first = -1;
    for (int n = 0; n < 9600; n++) begin
      tick();
      if (!vsync) begin
        lows++;
        if (first < 0) first = out_idx();
      end
    end
    chk("vs_width", lows, 1600);
    chk("vs_start", first, 490 * 800);

    cpu_wr(16'h3900, 8'h81);
    bus.cpu_address = 16'h7000;
    wait_out(799, 524);
    chk("vb_524", data, 8'h01);
    wait_out(0, 0);
    chk("vb_wrap", data, 8'h00);
    chk("f1_0_0", rgb(), 6'h01);
    wait_out(15, 15);
    chk("f1_15_15", rgb(), 6'h01);
    wait_out(16, 15);
    chk("f1_16_15", rgb(), 6'h2D);
    wait_out(0, 16);
    chk("f1_0_16", rgb(), 6'h07);

    wait_out(798, 479);
    chk("f1_irq_pre", bus.vblank_irq, 0);
    wait_out(799, 479);
    chk("f1_irq_set", bus.vblank_irq, 1);

    wait_out(0, 490);
    chk("f1_vs_low", vsync, 0);
    rst = 1'b1;
    tick();
    chk("mrst_hs", hsync, 1);
    chk("mrst_vs", vsync, 1);
    chk("mrst_rgb", rgb(), 0);
    chk("mrst_irq", bus.vblank_irq, 0);

    bus.cpu_address = 16'h3700;
    rst = 1'b0;
    tick();
    chk("mrst_vram", data, 8'hEA);
    chk("mrst_pix", rgb(), 6'h01);
    wait_out(655, 0);
    chk("mrst_hs655", hsync, 1);
    wait_out(656, 0);
    chk("mrst_hs656", hsync, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
